// File: rtl/alu_ctrl_pkg.sv
// Shared widths, FSM state encoding and command record for the ALU issue controller.
package alu_ctrl_pkg;
   localparam int DATA_W  = 8;
   localparam int FSEL_W  = 4;
   localparam int REG_NUM = 8;
   localparam int REG_AW  = $clog2(REG_NUM);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      RESP  = 2'd2
   } state_t;

   typedef struct packed {
      logic [FSEL_W-1:0] f;
      logic [REG_AW-1:0] ra;
      logic [REG_AW-1:0] rb;
      logic [REG_AW-1:0] rd;
      logic              wb;
   } cmd_t;
endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Command handshake and response bundle between the CPU control unit (master) and the ALU issue controller (slave).
interface alu_issue_ctrl_if;
   import alu_ctrl_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic [FSEL_W-1:0] cmd_f;
   logic [REG_AW-1:0] cmd_ra;
   logic [REG_AW-1:0] cmd_rb;
   logic [REG_AW-1:0] cmd_rd;
   logic              cmd_wb;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_c;
   logic              rsp_cf;
   logic              rsp_zf;

   modport master (
      output cmd_valid, cmd_f, cmd_ra, cmd_rb, cmd_rd, cmd_wb,
      input  cmd_ready, rsp_valid, rsp_c, rsp_cf, rsp_zf
   );

   modport slave (
      input  cmd_valid, cmd_f, cmd_ra, cmd_rb, cmd_rd, cmd_wb,
      output cmd_ready, rsp_valid, rsp_c, rsp_cf, rsp_zf
   );
endinterface

// File: rtl/alu_regfile.sv
// REG_NUM x DATA_W register file: three combinational read ports, one synchronous write port.
module alu_regfile
   import alu_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] ra_addr,
   input  logic [REG_AW-1:0] rb_addr,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [DATA_W-1:0] ra_data,
   output logic [DATA_W-1:0] rb_data,
   output logic [DATA_W-1:0] dbg_data,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [DATA_W-1:0] wdata
);
   logic [DATA_W-1:0] mem_q [REG_NUM];
   logic [DATA_W-1:0] mem_d [REG_NUM];

   always_comb begin
      mem_d = mem_q;
      if (we) mem_d[waddr] = wdata;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_NUM; i++) mem_q[i] <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   assign ra_data  = mem_q[ra_addr];
   assign rb_data  = mem_q[rb_addr];
   assign dbg_data = mem_q[dbg_addr];
endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage initiator for the combinational ALU: operand fetch, settle wait, result capture and write-back.
// Optional completed-op counter enabled by defining ALU_OPCNT_EN.
module alu_issue_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int SETTLE_CYC = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   alu_issue_ctrl_if.slave   cmd_if,
   input  logic              ld_valid,
   input  logic [REG_AW-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [FSEL_W-1:0] alu_f,
   input  logic [DATA_W-1:0] alu_c,
   input  logic              alu_cf,
   input  logic              alu_zf,
   output logic              cf_q,
   output logic              zf_q,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic [15:0]       op_count
);
   localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [REG_AW-1:0] rd_q, rd_d;
   logic              wb_q, wb_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [FSEL_W-1:0] alu_f_q, alu_f_d;
   logic [DATA_W-1:0] rsp_c_q, rsp_c_d;
   logic              rsp_cf_q, rsp_cf_d, rsp_zf_q, rsp_zf_d;
   logic              cf_d, zf_d;
   logic              capture;
   logic              rf_we;
   logic [REG_AW-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic [DATA_W-1:0] ra_data, rb_data;
   cmd_t              cmd_in;

   assign cmd_in = '{f: cmd_if.cmd_f, ra: cmd_if.cmd_ra, rb: cmd_if.cmd_rb,
                     rd: cmd_if.cmd_rd, wb: cmd_if.cmd_wb};

   alu_regfile u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .ra_addr  (cmd_in.ra),
      .rb_addr  (cmd_in.rb),
      .dbg_addr (dbg_addr),
      .ra_data  (ra_data),
      .rb_data  (rb_data),
      .dbg_data (dbg_data),
      .we       (rf_we),
      .waddr    (rf_waddr),
      .wdata    (rf_wdata)
   );

   // Preload only happens in IDLE and write-back only in DRIVE, so the write port never sees both.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rd_d     = rd_q;
      wb_d     = wb_q;
      alu_a_d  = alu_a_q;
      alu_b_d  = alu_b_q;
      alu_f_d  = alu_f_q;
      rsp_c_d  = rsp_c_q;
      rsp_cf_d = rsp_cf_q;
      rsp_zf_d = rsp_zf_q;
      cf_d     = cf_q;
      zf_d     = zf_q;
      capture  = 1'b0;
      rf_we    = 1'b0;
      rf_waddr = ld_addr;
      rf_wdata = ld_data;
      unique case (state_q)
         IDLE: begin
            rf_we = ld_valid;
            if (cmd_if.cmd_valid) begin
               alu_a_d = ra_data;
               alu_b_d = rb_data;
               alu_f_d = cmd_in.f;
               rd_d    = cmd_in.rd;
               wb_d    = cmd_in.wb;
               cnt_d   = CNT_W'(SETTLE_CYC - 1);
               state_d = DRIVE;
            end
         end
         DRIVE: begin
            if (cnt_q == '0) begin
               capture  = 1'b1;
               rsp_c_d  = alu_c;
               rsp_cf_d = alu_cf;
               rsp_zf_d = alu_zf;
               cf_d     = alu_cf;
               zf_d     = alu_zf;
               rf_we    = wb_q;
               rf_waddr = rd_q;
               rf_wdata = alu_c;
               state_d  = RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rd_q     <= '0;
         wb_q     <= 1'b0;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         alu_f_q  <= '0;
         rsp_c_q  <= '0;
         rsp_cf_q <= 1'b0;
         rsp_zf_q <= 1'b0;
         cf_q     <= 1'b0;
         zf_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rd_q     <= rd_d;
         wb_q     <= wb_d;
         alu_a_q  <= alu_a_d;
         alu_b_q  <= alu_b_d;
         alu_f_q  <= alu_f_d;
         rsp_c_q  <= rsp_c_d;
         rsp_cf_q <= rsp_cf_d;
         rsp_zf_q <= rsp_zf_d;
         cf_q     <= cf_d;
         zf_q     <= zf_d;
      end
   end

`ifdef ALU_OPCNT_EN
   logic [15:0] op_count_q, op_count_d;

   always_comb begin
      op_count_d = op_count_q;
      if (capture && op_count_q != 16'hFFFF) op_count_d = op_count_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) op_count_q <= '0;
      else        op_count_q <= op_count_d;
   end

   assign op_count = op_count_q;
`else
   assign op_count = '0;
`endif

   assign cmd_if.cmd_ready = (state_q == IDLE);
   assign cmd_if.rsp_valid = (state_q == RESP);
   assign cmd_if.rsp_c     = rsp_c_q;
   assign cmd_if.rsp_cf    = rsp_cf_q;
   assign cmd_if.rsp_zf    = rsp_zf_q;
   assign alu_a            = alu_a_q;
   assign alu_b            = alu_b_q;
   assign alu_f            = alu_f_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with an adder stub standing in for the ALU (F=0 -> A+B).
module tb_alu_issue_ctrl;
   import alu_ctrl_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              ld_valid;
   logic [REG_AW-1:0] ld_addr;
   logic [DATA_W-1:0] ld_data;
   logic [DATA_W-1:0] alu_a, alu_b, alu_c;
   logic [FSEL_W-1:0] alu_f;
   logic              alu_cf, alu_zf;
   logic              cf_q, zf_q;
   logic [REG_AW-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_data;
   logic [15:0]       op_count;
   logic [DATA_W:0]   sum;

   int n_vec = 0;
   int n_err = 0;

   alu_issue_ctrl_if cmd_if ();

   alu_issue_ctrl #(.SETTLE_CYC(1)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cmd_if   (cmd_if),
      .ld_valid (ld_valid),
      .ld_addr  (ld_addr),
      .ld_data  (ld_data),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_f    (alu_f),
      .alu_c    (alu_c),
      .alu_cf   (alu_cf),
      .alu_zf   (alu_zf),
      .cf_q     (cf_q),
      .zf_q     (zf_q),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data),
      .op_count (op_count)
   );

   always #5 clk = ~clk;

   assign sum    = (alu_f == '0) ? ({1'b0, alu_a} + {1'b0, alu_b}) : '0;
   assign alu_c  = sum[DATA_W-1:0];
   assign alu_cf = sum[DATA_W];
   assign alu_zf = (alu_c == '0);

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int addr, input int data);
      ld_valid = 1'b1;
      ld_addr  = REG_AW'(addr);
      ld_data  = DATA_W'(data);
      tick();
      ld_valid = 1'b0;
   endtask

   task automatic set_cmd(input int ra, input int rb, input int rd, input bit wb);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_f     = '0;
      cmd_if.cmd_ra    = REG_AW'(ra);
      cmd_if.cmd_rb    = REG_AW'(rb);
      cmd_if.cmd_rd    = REG_AW'(rd);
      cmd_if.cmd_wb    = wb;
   endtask

   task automatic read_reg(input string tag, input int addr, input int exp);
      dbg_addr = REG_AW'(addr);
      #1;
      check_eq(tag, 32'(dbg_data), 32'(exp));
   endtask

   int n_acc, n_rsp, n_busy;

   initial begin
      rst_n = 1'b0;
      ld_valid = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
      cmd_if.cmd_valid = 1'b0; cmd_if.cmd_f = '0; cmd_if.cmd_ra = '0;
      cmd_if.cmd_rb = '0; cmd_if.cmd_rd = '0; cmd_if.cmd_wb = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      check_eq("rst_ready", 32'(cmd_if.cmd_ready), 1);
      check_eq("rst_rsp_valid", 32'(cmd_if.rsp_valid), 0);
      check_eq("rst_alu_a", 32'(alu_a), 0);
      check_eq("rst_op_count", 32'(op_count), 0);

      // Add 0x0F + 0xF1 with write-back into R3 (preloaded non-zero)
      load(1, 8'h0F); load(2, 8'hF1); load(3, 8'h77);
      set_cmd(1, 2, 3, 1'b1);
      check_eq("t2_ready_idle", 32'(cmd_if.cmd_ready), 1);
      tick();
      cmd_if.cmd_valid = 1'b0;
      check_eq("t2_alu_a", 32'(alu_a), 32'h0F);
      check_eq("t2_alu_b", 32'(alu_b), 32'hF1);
      check_eq("t2_ready_drive", 32'(cmd_if.cmd_ready), 0);
      check_eq("t2_rsp_early", 32'(cmd_if.rsp_valid), 0);
      tick();
      check_eq("t2_rsp_valid", 32'(cmd_if.rsp_valid), 1);
      check_eq("t2_rsp_c", 32'(cmd_if.rsp_c), 0);
      check_eq("t2_rsp_cf", 32'(cmd_if.rsp_cf), 1);
      check_eq("t2_rsp_zf", 32'(cmd_if.rsp_zf), 1);
      check_eq("t2_cf_q", 32'(cf_q), 1);
      check_eq("t2_zf_q", 32'(zf_q), 1);
      tick();
      check_eq("t2_rsp_drop", 32'(cmd_if.rsp_valid), 0);
      check_eq("t2_rsp_c_hold", 32'(cmd_if.rsp_c), 0);
      read_reg("t2_r3", 3, 8'h00);

      // cmd_valid held for six cycles: two accepts, two responses
      set_cmd(1, 2, 7, 1'b0);
      n_acc = 0; n_rsp = 0; n_busy = 0;
      for (int i = 0; i < 6; i++) begin
         if (cmd_if.cmd_ready) n_acc++; else n_busy++;
         if (cmd_if.rsp_valid) n_rsp++;
         tick();
      end
      cmd_if.cmd_valid = 1'b0;
      check_eq("t3_accepts", 32'(n_acc), 2);
      check_eq("t3_rsps", 32'(n_rsp), 2);
      check_eq("t3_busy_cycles", 32'(n_busy), 4);
      check_eq("t3_idle_again", 32'(cmd_if.cmd_ready), 1);

      // Same-cycle preload and command: command sees the old R1
      load(1, 8'h10);
      ld_valid = 1'b1; ld_addr = 3'd1; ld_data = 8'h55;
      set_cmd(1, 1, 4, 1'b1);
      tick();
      ld_valid = 1'b0; cmd_if.cmd_valid = 1'b0;
      check_eq("t4_alu_a", 32'(alu_a), 32'h10);
      tick();
      check_eq("t4_rsp_c", 32'(cmd_if.rsp_c), 32'h20);
      tick();
      read_reg("t4_r1", 1, 8'h55);
      read_reg("t4_r4", 4, 8'h20);

      // Reset during DRIVE abandons the op
      load(5, 8'hAA);
      set_cmd(1, 2, 5, 1'b1);
      tick();
      cmd_if.cmd_valid = 1'b0;
      check_eq("t5_in_drive", 32'(cmd_if.cmd_ready), 0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_eq("t5_rsp_valid", 32'(cmd_if.rsp_valid), 0);
      check_eq("t5_ready", 32'(cmd_if.cmd_ready), 1);
      check_eq("t5_alu_a", 32'(alu_a), 0);
      check_eq("t5_alu_b", 32'(alu_b), 0);
      check_eq("t5_rsp_c", 32'(cmd_if.rsp_c), 0);
      check_eq("t5_cf_q", 32'(cf_q), 0);
      for (int a = 0; a < REG_NUM; a++) read_reg($sformatf("t5_r%0d", a), a, 0);
      tick();
      check_eq("t5_rsp_after", 32'(cmd_if.rsp_valid), 0);

      // wb=0: flags/response update, register file untouched
      load(1, 8'h01); load(2, 8'h01); load(6, 8'h33);
      set_cmd(1, 2, 6, 1'b0);
      tick();
      cmd_if.cmd_valid = 1'b0;
      tick();
      check_eq("t6_rsp_valid", 32'(cmd_if.rsp_valid), 1);
      check_eq("t6_rsp_c", 32'(cmd_if.rsp_c), 32'h02);
      check_eq("t6_cf_q", 32'(cf_q), 0);
      check_eq("t6_zf_q", 32'(zf_q), 0);
      tick();
      read_reg("t6_r6", 6, 8'h33);
`ifdef ALU_OPCNT_EN
      check_eq("t6_op_count", 32'(op_count), 1);
`else
      check_eq("t6_op_count", 32'(op_count), 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
